match_req_scheduler: RTL
========================

// Module: match_req_scheduler
// PURPOSE
//  Takes one lazy-match request group (L slots) from a job_pe and issues each valid slot to one of
//  C match request channels. The channel tag carries the slot index. The block announces the group
//  to match_resp_sync (req_group_valid/strb) and holds off the next group until the collected
//  response group has been consumed. One group is in flight at a time.
// PARAMETERS
//  L        `LAZY_LEN          slots per group
//  C        `NUM_MATCH_REQ_CH  match request channels
//  TAG_BITS `LAZY_LEN_LOG2     tag width = slot index width
//  AW       `ADDR_WIDTH        history address width per slot
// PORTS
//  clk             in   1         clock
//  rst             in   1         asynchronous, active-high reset
//  in_valid        in   1         job_pe group valid
//  in_ready        out  1         group accepted when in_valid&&in_ready
//  in_strb         in   L         slot i requires a match when set
//  in_addr         in   L*AW      slot i address at [i*AW +: AW]
//  req_ch_valid    out  C         per-channel request valid
//  req_ch_ready    in   C         per-channel request ready
//  req_ch_tag      out  C*TAG_BITS  slot index presented on channel j
//  req_ch_addr     out  C*AW      address presented on channel j
//  sync_grp_valid  out  1         one-cycle pulse to match_resp_sync.req_group_valid
//  sync_grp_strb   out  L         to match_resp_sync.req_group_strb, valid with the pulse
//  resp_grp_valid  in   1         snooped match_resp_sync.resp_group_valid
//  resp_grp_ready  in   1         snooped consumer ready
//  err             out  1         sticky protocol-error flag
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=0 while rst is asserted, then 1 in IDLE.
//    Reset clears req_ch_valid, sync_grp_valid, err, pending and all channel regs (tag/addr=0).
//  - FSM IDLE->ISSUE:
//    . in_ready = (state==IDLE).
//    . Trigger: accept edge T. At that edge: pending<=in_strb, addr_q<=in_addr, strb_q<=in_strb.
//    . sync_grp_valid=1 during cycle T+1 only, with sync_grp_strb=strb_q. strb_q is held until the next accept.
//  - ISSUE:
//    . Each channel has a holding reg {valid,tag,addr}. A channel is "free" if !valid or (valid&&ready).
//    . Free channels, in ascending j, each take the lowest-index pending, unassigned slot at the clock edge.
//    . Taking a slot clears that slot's pending bit.
//    . A firing channel may reload at the same edge (back-to-back issue).
//    . Consequently no req_ch_valid rises before T+2, so sync has already latched strb before any response can return.
//    . Once valid, a channel holds tag/addr stable until ready (no retraction, no reassignment).
//    . Slot-to-channel mapping is not fixed; tag = slot index is the only identifier.
//  - ISSUE->WAIT: when pending==0 and every channel is free this cycle.
//    . strb=0 groups: go ISSUE->WAIT after one cycle; match_resp_sync completes immediately.
//  - WAIT->IDLE: on resp_grp_valid&&resp_grp_ready. in_ready=1 in the following cycle; no same-cycle bypass.
//  - Protocol errors: a resp_grp handshake in IDLE or ISSUE sets err (sticky until reset).
//    The FSM ignores it; an ISSUE->IDLE transition is never taken.
//  - Tag width: slot index zero-extended/truncated to TAG_BITS; L <= 2**TAG_BITS is required.
//  - Throughput: at most C slots issued per cycle; a full group with all channels ready takes ceil(L/C) cycles.
//  - Reset mid-operation: all state drops immediately and in-flight requests are forgotten.
//    Upstream match_pe/resp_sync are reset together with this block.
// STRUCTURE
//  - parameters.vh supplies LAZY_LEN, LAZY_LEN_LOG2, NUM_MATCH_REQ_CH, ADDR_WIDTH.
//  - FSM state encoding localparams stay local.
//  - One sub-module: match_slot_picker. Combinational: given the pending mask and the free-channel mask, it
//    returns per-channel {take, slot_idx} and the next pending mask via a lowest-set-bit cascade over C channels.
//  - The top level holds the FSM, channel regs, addr/strb regs and err.
// TESTING  (L=4, C=2)
//  1. strb=4'b1111, all ready=1:
//     -> T+1 pulse, strb=1111; T+2 ch0 tag0, ch1 tag1; T+3 ch0 tag2, ch1 tag3; T+4 WAIT.
//  2. strb=4'b1010, ch1 ready=0:
//     -> T+2 ch0 tag1, ch1 tag3; ch1 holds tag3/addr3 stable until ready; no further issue.
//  3. strb=4'b0000:
//     -> pulse with strb=0, no req_ch_valid; WAIT until resp_grp handshake; in_ready=1 one cycle after the handshake.
//  4. in_valid held high during ISSUE/WAIT -> in_ready=0 and no second accept until WAIT completes.
//  5. resp_grp_valid&&ready injected in ISSUE -> err=1, FSM stays ISSUE, remaining slots still issued.
//  6. rst asserted with ch0 valid mid-ISSUE -> req_ch_valid=0 and in_ready=0 immediately, in_ready=1 after release.
//     A new group then issues from slot 0.

Source files
------------

// File: rtl/match_req_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// match_req_scheduler_pkg : default sizing shared by the scheduler files
// Rev 1.0
// ---------------------------------------------------------------------------
package match_req_scheduler_pkg;

    localparam int LAZY_LEN         = 4;
    localparam int LAZY_LEN_LOG2    = 2;
    localparam int NUM_MATCH_REQ_CH = 2;
    localparam int ADDR_WIDTH       = 8;

endpackage
`default_nettype wire

// File: rtl/match_slot_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// match_slot_picker : lowest-set-bit cascade handing pending slots to free channels
// Rev 1.0
// ---------------------------------------------------------------------------
module match_slot_picker
    import match_req_scheduler_pkg::*;
#(
    parameter int L        = LAZY_LEN,
    parameter int C        = NUM_MATCH_REQ_CH,
    parameter int TAG_BITS = LAZY_LEN_LOG2
) (
    input  logic [L-1:0]                 i_pending,
    input  logic [C-1:0]                 i_free,
    output logic [C-1:0]                 o_take,
    output logic [C-1:0][TAG_BITS-1:0]   o_idx,
    output logic [L-1:0]                 o_pending_nxt
);

    logic [L-1:0] w_rem;
    logic         w_hit;

    always_comb begin
        w_rem  = i_pending;
        w_hit  = 1'b0;
        o_take = '0;
        o_idx  = '0;
        // Each channel in ascending order removes the lowest remaining slot.
        for (int j = 0; j < C; j++) begin
            w_hit = 1'b0;
            for (int i = 0; i < L; i++) begin
                if (i_free[j] && w_rem[i] && !w_hit) begin
                    w_hit     = 1'b1;
                    w_rem[i]  = 1'b0;
                    o_take[j] = 1'b1;
                    o_idx[j]  = TAG_BITS'(i);
                end
            end
        end
        o_pending_nxt = w_rem;
    end

endmodule
`default_nettype wire

// File: rtl/match_req_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// match_req_scheduler : issues one lazy-match slot group over C request channels
// Rev 1.0
// ---------------------------------------------------------------------------
module match_req_scheduler
    import match_req_scheduler_pkg::*;
#(
    parameter int L        = LAZY_LEN,
    parameter int C        = NUM_MATCH_REQ_CH,
    parameter int TAG_BITS = LAZY_LEN_LOG2,
    parameter int AW       = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [L-1:0]          in_strb,
    input  logic [L*AW-1:0]       in_addr,
    output logic [C-1:0]          req_ch_valid,
    input  logic [C-1:0]          req_ch_ready,
    output logic [C*TAG_BITS-1:0] req_ch_tag,
    output logic [C*AW-1:0]       req_ch_addr,
    output logic                  sync_grp_valid,
    output logic [L-1:0]          sync_grp_strb,
    input  logic                  resp_grp_valid,
    input  logic                  resp_grp_ready,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [L-1:0]                 r_pending;
    logic [L-1:0]                 r_strb_q;
    logic [L-1:0][AW-1:0]         r_addr_q;
    logic [C-1:0]                 r_ch_valid;
    logic [C-1:0][TAG_BITS-1:0]   r_ch_tag;
    logic [C-1:0][AW-1:0]         r_ch_addr;
    logic                         r_sync;
    logic                         r_err;

    logic                         w_accept;
    logic                         w_resp_hs;
    logic [C-1:0]                 w_free;
    logic [C-1:0]                 w_pick_free;
    logic [C-1:0]                 w_take;
    logic [C-1:0][TAG_BITS-1:0]   w_idx;
    logic [L-1:0]                 w_pending_nxt;

    assign in_ready    = (r_state == S_IDLE) && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_resp_hs   = resp_grp_valid && resp_grp_ready;
    assign w_free      = ~r_ch_valid | req_ch_ready;
    assign w_pick_free = (r_state == S_ISSUE) ? w_free : '0;

    match_slot_picker #(
        .L        (L),
        .C        (C),
        .TAG_BITS (TAG_BITS)
    ) u_picker (
        .i_pending     (r_pending),
        .i_free        (w_pick_free),
        .o_take        (w_take),
        .o_idx         (w_idx),
        .o_pending_nxt (w_pending_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: if ((r_pending == '0) && (&w_free)) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_resp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_strb_q   <= '0;
            r_addr_q   <= '0;
            r_ch_valid <= '0;
            r_ch_tag   <= '0;
            r_ch_addr  <= '0;
            r_sync     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync  <= w_accept;
            if (w_accept) begin
                r_pending <= in_strb;
                r_strb_q  <= in_strb;
                r_addr_q  <= in_addr;
            end else if (r_state == S_ISSUE) begin
                r_pending <= w_pending_nxt;
            end
            // A channel that fires this edge may be reloaded at the same edge.
            for (int j = 0; j < C; j++) begin
                if (w_take[j]) begin
                    r_ch_valid[j] <= 1'b1;
                    r_ch_tag[j]   <= w_idx[j];
                    r_ch_addr[j]  <= r_addr_q[w_idx[j]];
                end else if (req_ch_ready[j]) begin
                    r_ch_valid[j] <= 1'b0;
                end
            end
            if (w_resp_hs && (r_state != S_WAIT)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_ch_valid   = r_ch_valid;
    assign req_ch_tag     = r_ch_tag;
    assign req_ch_addr    = r_ch_addr;
    assign sync_grp_valid = r_sync;
    assign sync_grp_strb  = r_strb_q;
    assign err            = r_err;

endmodule
`default_nettype wire
